// File: rtl/pnl_bram_ctrl.sv
// pnl_bram_ctrl: owns port A of a single-port 8192x16 synchronous BRAM
// (1-cycle registered read). Loads a counted burst from a valid/ready source
// into addresses 0.. and replays any address range as a valid-qualified stream.
//
// Optional feature macro: PNL_BRAM_CTRL_CHECKSUM_EN
//   defined   -> wr_sum / rd_sum carry 16-bit wrapping sums of loaded / emitted words
//   undefined -> wr_sum / rd_sum are tied to zero (ports kept)
//
// Handshake: a source word moves only on a cycle where data_valid and
// data_ready are both high at the rising edge; data_ready depends on state
// only, never on data_valid. The output stream has no ready: every cycle with
// data_out_valid high carries one word that downstream must take.
module pnl_bram_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] read_base,
  input  logic [ADDR_W:0]   read_len,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] wr_sum,
  output logic [DATA_W-1:0] rd_sum,
  output logic [ADDR_W-1:0] BRAM_PORTA_addr,
  output logic [DATA_W-1:0] BRAM_PORTA_dout,
  input  logic [DATA_W-1:0] BRAM_PORTA_din,
  output logic              BRAM_PORTA_we,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WLAST  = 3'd2,
    READ   = 3'd3,
    RDRAIN = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wptr, rptr, addr_q;
  logic [ADDR_W:0]     cnt;          // words still to transfer / addresses still to issue
  logic [DATA_W-1:0]   dout_q;
  logic                we_q, issue_q, valid_q, done_q;
  logic                xfer, start_load, start_read, load_go, read_go, done_nxt;

  // Start decode: load has priority; both are only honoured in IDLE.
  assign start_load = (state == IDLE) && load_start;
  assign start_read = (state == IDLE) && !load_start && read_start;
  assign load_go    = start_load && (load_len != '0);
  assign read_go    = start_read && (read_len != '0);
  assign xfer       = (state == WRITE) && data_valid;

  assign data_ready      = (state == WRITE);
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign data_out        = BRAM_PORTA_din;
  assign data_out_valid  = valid_q;
  assign BRAM_PORTA_addr = addr_q;
  assign BRAM_PORTA_dout = dout_q;
  assign BRAM_PORTA_we   = we_q;
  assign state_dbg       = state;

  // State register.
  always_ff @(posedge Clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the done request (zero-length starts finish at once).
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load_go)      state_nxt = WRITE;
        else if (read_go) state_nxt = READ;
        done_nxt = (start_load && !load_go) || (start_read && !read_go);
      end
      WRITE:  if (xfer && (cnt == CNT_ONE)) state_nxt = WLAST;
      WLAST:  begin state_nxt = IDLE; done_nxt = 1'b1; end
      READ:   if (cnt == '0) state_nxt = RDRAIN;
      RDRAIN: begin state_nxt = IDLE; done_nxt = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: BRAM port registers, pointers, counter, read-latency tracking.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      wptr    <= '0;
      rptr    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      issue_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q    <= xfer;
      issue_q <= 1'b0;
      valid_q <= issue_q;    // BRAM data appears one cycle after its address
      done_q  <= done_nxt;
      case (state)
        IDLE: begin
          if (load_go) begin
            wptr <= '0;
            cnt  <= load_len;
          end else if (read_go) begin
            addr_q  <= read_base;
            rptr    <= read_base + ADDR_ONE;
            cnt     <= read_len - CNT_ONE;
            issue_q <= 1'b1;
          end
        end
        WRITE: begin
          if (xfer) begin
            addr_q <= wptr;
            dout_q <= data_in;
            wptr   <= wptr + ADDR_ONE;
            cnt    <= cnt - CNT_ONE;
          end
        end
        READ: begin
          if (cnt != '0) begin
            addr_q  <= rptr;
            rptr    <= rptr + ADDR_ONE;   // wraps 8191 -> 0 naturally
            cnt     <= cnt - CNT_ONE;
            issue_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PNL_BRAM_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] wr_sum_q, rd_sum_q;

  // Running checksums, cleared by the start that opens each operation.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      wr_sum_q <= '0;
      rd_sum_q <= '0;
    end else begin
      if (start_load)   wr_sum_q <= '0;
      else if (xfer)    wr_sum_q <= wr_sum_q + data_in;
      if (start_read)   rd_sum_q <= '0;
      else if (valid_q) rd_sum_q <= rd_sum_q + BRAM_PORTA_din;
    end
  end

  assign wr_sum = wr_sum_q;
  assign rd_sum = rd_sum_q;
`else
  assign wr_sum = '0;
  assign rd_sum = '0;
`endif

endmodule

// File: tb/tb_pnl_bram_ctrl.sv
// Testbench for pnl_bram_ctrl: behavioural BRAM model, directed stimulus,
// scoreboard queues for BRAM writes and output words, timing checks on done.
module tb_pnl_bram_ctrl;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              Clk = 1'b0;
  logic              RESET = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              read_start = 1'b0;
  logic [ADDR_W-1:0] read_base = '0;
  logic [ADDR_W:0]   read_len = '0;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              busy, done;
  logic [DATA_W-1:0] wr_sum, rd_sum;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] bram_din = '0;
  logic              bram_we;
  logic [2:0]        state_dbg;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int valid_cnt = 0;
  int first_valid_cyc = 0;
  bit first_armed = 0;
  bit ignore_valid = 0;

  logic [DATA_W-1:0]        exp_q[$];     // expected output words
  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];  // expected {addr, data} BRAM writes
  logic [DATA_W-1:0]        ld_words[$];  // words for the next load

`ifdef PNL_BRAM_CTRL_CHECKSUM_EN
  localparam logic [DATA_W-1:0] EXP_SUM = 16'h0006;
`else
  localparam logic [DATA_W-1:0] EXP_SUM = 16'h0000;
`endif

  pnl_bram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .RESET(RESET),
    .load_start(load_start), .load_len(load_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .read_start(read_start), .read_base(read_base), .read_len(read_len),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .busy(busy), .done(done), .wr_sum(wr_sum), .rd_sum(rd_sum),
    .BRAM_PORTA_addr(bram_addr), .BRAM_PORTA_dout(bram_dout),
    .BRAM_PORTA_din(bram_din), .BRAM_PORTA_we(bram_we),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;
  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // BRAM model: write-enable store, registered read.
  always @(posedge Clk) begin
    if (bram_we) mem[bram_addr] <= bram_dout;
    bram_din <= mem[bram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge Clk);
    if (bram_we) begin
      we_cnt++;
      if (exp_wr_q.size() == 0) check("unexpected_write", {19'd0, bram_addr}, 32'hFFFF_FFFF);
      else check("bram_write", {3'd0, bram_addr, bram_dout}, {3'd0, exp_wr_q.pop_front()});
    end
    if (data_out_valid) begin
      valid_cnt++;
      if (first_armed) begin
        first_valid_cyc = cyc;
        first_armed = 0;
      end
      if (!ignore_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", {16'd0, data_out}, 32'hFFFF_FFFF);
        else check("read_data", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for done; e is the cycle index of the start edge. Checks latency,
  // the number of busy cycles before done, and that done lasts one cycle.
  task automatic wait_done(input int e, input int delay, input string name);
    int bc = 0;
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge Clk);
      if (done) begin
        seen = 1;
        check({name, "_done_latency"}, cyc - e, delay);
        check({name, "_busy_cycles"}, bc, delay);
        check({name, "_busy_low_at_done"}, {31'd0, busy}, 0);
        @(negedge Clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 0);
      end else if (busy) begin
        bc++;
      end
    end
    check({name, "_done_seen"}, {31'd0, seen}, 1);
  endtask

  // Load ld_words; pattern bit k is data_valid for the k-th cycle after the
  // start edge. rd_poke >= 0 pulses read_start on that cycle (must be ignored).
  task automatic do_load(input logic [15:0] pattern, input int rd_poke, input int delay,
                         input string name);
    int e;
    int n;
    n = ld_words.size();
    @(posedge Clk); #1;
    load_start = 1'b1;
    load_len   = n[ADDR_W:0];
    @(posedge Clk);
    e = cyc;
    #1 load_start = 1'b0;
    fork
      begin
        int idx = 0;
        for (int k = 0; k < 16 && idx < n; k++) begin
          data_valid = pattern[k];
          read_start = (k == rd_poke);
          read_base  = '0;
          read_len   = 14'd2;
          if (pattern[k]) begin
            data_in = ld_words[idx];
            exp_wr_q.push_back({idx[ADDR_W-1:0], ld_words[idx]});
          end
          @(posedge Clk); #1;
          if (pattern[k]) idx++;
        end
        data_valid = 1'b0;
        read_start = 1'b0;
      end
      wait_done(e, delay, name);
    join
    ld_words.delete();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] base, input int len, input int delay,
                         input string name);
    int e;
    @(posedge Clk); #1;
    read_start  = 1'b1;
    read_base   = base;
    read_len    = len[ADDR_W:0];
    first_armed = (len > 0);
    @(posedge Clk);
    e = cyc;
    #1 read_start = 1'b0;
    wait_done(e, delay, name);
    if (len > 0) check({name, "_first_valid"}, first_valid_cyc - e, 1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_data_ready"}, {31'd0, data_ready}, 0);
    check({name, "_data_out_valid"}, {31'd0, data_out_valid}, 0);
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_done"}, {31'd0, done}, 0);
    check({name, "_we"}, {31'd0, bram_we}, 0);
    check({name, "_addr"}, {19'd0, bram_addr}, 0);
    check({name, "_dout"}, {16'd0, bram_dout}, 0);
    check({name, "_wr_sum"}, {16'd0, wr_sum}, 0);
    check({name, "_rd_sum"}, {16'd0, rd_sum}, 0);
    check({name, "_state"}, {29'd0, state_dbg}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int v0, w0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[8190] = 16'hA5A5;
    mem[8191] = 16'h5A5A;

    // Power-on reset
    RESET = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_values("por");
    RESET = 1'b0;

    // Load 2 words, no stalls: done 3 negedges after start edge (edge E+4)
    ld_words.push_back(16'h0001);
    ld_words.push_back(16'hFFFF);
    w0 = we_cnt;
    do_load(16'hFFFF, -1, 3, "load2");
    check("load2_we_cycles", we_cnt - w0, 2);
    check("load2_mem0", {16'd0, mem[0]}, 32'h0001);
    check("load2_mem1", {16'd0, mem[1]}, 32'hFFFF);

    // Load 4 words, data_valid on alternate cycles: transfers at E+1,3,5,7
    ld_words.push_back(16'h1111);
    ld_words.push_back(16'h2222);
    ld_words.push_back(16'h3333);
    ld_words.push_back(16'h4444);
    w0 = we_cnt;
    do_load(16'h0055, -1, 8, "load4_stall");
    check("load4_we_cycles", we_cnt - w0, 4);
    check("load4_mem3", {16'd0, mem[3]}, 32'h4444);

    // Wrapping read 8190..1
    exp_q.push_back(16'hA5A5);
    exp_q.push_back(16'h5A5A);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    v0 = valid_cnt;
    do_read(13'd8190, 4, 5, "read_wrap");
    check("read_wrap_valid_count", valid_cnt - v0, 4);

    // Simultaneous starts, load_len=0: one done, no write, read dropped
    w0 = we_cnt;
    v0 = valid_cnt;
    @(posedge Clk); #1;
    load_start = 1'b1; load_len = '0;
    read_start = 1'b1; read_base = 13'd5; read_len = 14'd3;
    @(posedge Clk);
    begin
      int e;
      e = cyc;
      #1 load_start = 1'b0; read_start = 1'b0;
      wait_done(e, 0, "both_zero");
    end
    repeat (6) @(negedge Clk);
    check("both_zero_no_write", we_cnt - w0, 0);
    check("both_zero_no_read", valid_cnt - v0, 0);
    check("both_zero_idle", {29'd0, state_dbg}, 0);

    // Load 3 words with stall, read_start poked during WRITE (ignored)
    ld_words.push_back(16'h8000);
    ld_words.push_back(16'h8001);
    ld_words.push_back(16'h0005);
    v0 = valid_cnt;
    do_load(16'h000D, 1, 5, "load3_poke");
    check("load3_no_read", valid_cnt - v0, 0);
    check("load3_wr_sum", {16'd0, wr_sum}, {16'd0, EXP_SUM});
    check("load3_rd_sum_idle", {16'd0, rd_sum}, 0);

    // Read back 0..2
    exp_q.push_back(16'h8000);
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h0005);
    do_read(13'd0, 3, 4, "read3");
    check("read3_rd_sum", {16'd0, rd_sum}, {16'd0, EXP_SUM});
    repeat (3) @(negedge Clk);
    check("read3_rd_sum_hold", {16'd0, rd_sum}, {16'd0, EXP_SUM});
    check("read3_wr_sum_hold", {16'd0, wr_sum}, {16'd0, EXP_SUM});

    // Zero-length read: immediate done
    v0 = valid_cnt;
    do_read(13'd7, 0, 0, "read0");
    check("read0_no_valid", valid_cnt - v0, 0);

    // Reset for 5 cycles in the middle of a long read
    ignore_valid = 1;
    @(posedge Clk); #1;
    read_start = 1'b1; read_base = '0; read_len = 14'd20;
    @(posedge Clk); #1;
    read_start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    check("midread_busy", {31'd0, busy}, 1);
    RESET = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check_reset_values("midread_reset");
    repeat (4) @(posedge Clk);
    #1 RESET = 1'b0;
    v0 = valid_cnt;
    repeat (10) @(negedge Clk);
    check("midread_no_more_valid", valid_cnt - v0, 0);
    check("midread_idle", {29'd0, state_dbg}, 0);
    ignore_valid = 0;

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_wr_q_drained", exp_wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
